// File: rtl/package_settings_v2.sv
// Shared settings for the ADC-side datapath: sample width, pulse-emulator defaults and
// the period-timer state type.
package package_settings_v2;

    localparam int SIZE_ADC_DATA       = 12;
    localparam int DECAY_SHIFT_DEFAULT = 4;
    localparam int EMU_FRAC_BITS       = 8;

    typedef enum logic {EMU_IDLE, EMU_COUNT} emu_state_t;

endpackage

// File: rtl/emu_period_timer.sv
// Auto-trigger timer: tick on auto_en rise, then once every max(period,1) sample strobes.
// Latency: tick is combinational from state/inputs; no backpressure, counts sample_en only.
module emu_period_timer
    import package_settings_v2::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic                auto_en,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    emu_state_t          state, state_nxt;
    logic [PERIOD_W-1:0] cnt, cnt_nxt;
    logic [PERIOD_W-1:0] reload;

    // period is only looked at here, so a change lands at the next reload
    assign reload = (period == '0) ? PERIOD_W'(1) : period;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMU_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tick      = 1'b0;
        case (state)
            EMU_IDLE: begin
                if (auto_en) begin
                    state_nxt = EMU_COUNT;
                    cnt_nxt   = reload;
                    tick      = 1'b1;
                end
            end
            EMU_COUNT: begin
                if (!auto_en) begin
                    state_nxt = EMU_IDLE;
                    cnt_nxt   = '0;
                end else if (sample_en) begin
                    if (cnt <= PERIOD_W'(1)) begin
                        tick    = 1'b1;
                        cnt_nxt = reload;
                    end else begin
                        cnt_nxt = cnt - PERIOD_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = EMU_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/pulse_emulator.sv
// Synthetic detector pulses: baseline plus exponentially decaying, piling-up pulses.
// Latency: one cycle from sample_en (and a coincident trigger) to adc_data; paced by sample_en.
module pulse_emulator
    import package_settings_v2::*;
#(
    parameter int DECAY_SHIFT = DECAY_SHIFT_DEFAULT,
    parameter int FRAC_BITS   = EMU_FRAC_BITS,
    parameter int PERIOD_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_en,
    input  logic                     start,
    input  logic                     auto_en,
    input  logic [PERIOD_W-1:0]      period,
    input  logic [SIZE_ADC_DATA-1:0] amplitude,
    input  logic [SIZE_ADC_DATA-1:0] baseline,
    output logic [SIZE_ADC_DATA-1:0] adc_data,
    output logic                     data_valid,
    output logic                     pulse_start,
    output logic                     busy
);

    localparam int ACC_W = SIZE_ADC_DATA + FRAC_BITS + 1;
    localparam int INT_W = SIZE_ADC_DATA + 1;

    logic [ACC_W-1:0]         acc, acc_nxt, decay;
    logic [ACC_W:0]           amp_ext, sum;
    logic [INT_W:0]           out_sum;
    logic [SIZE_ADC_DATA-1:0] adc_nxt;
    logic                     pend, tick, trig, inject;

    emu_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .auto_en   (auto_en),
        .period    (period),
        .tick      (tick)
    );

    assign trig    = start | tick;
    assign inject  = pend | trig;
    assign amp_ext = {{(ACC_W + 1 - SIZE_ADC_DATA){1'b0}}, amplitude} << FRAC_BITS;
    assign sum     = {1'b0, acc} + amp_ext;
    assign decay   = acc >> DECAY_SHIFT;

    always_comb begin
        acc_nxt = acc;
        if (inject) begin
            acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        end else if (decay == '0) begin
            // tail flush: guarantees the accumulator lands on exactly zero
            acc_nxt = '0;
        end else begin
            acc_nxt = acc - decay;
        end
    end

    assign out_sum = {2'b00, baseline} + {1'b0, acc_nxt[ACC_W-1:FRAC_BITS]};
    assign adc_nxt = (out_sum[INT_W:SIZE_ADC_DATA] != '0) ? {SIZE_ADC_DATA{1'b1}}
                                                           : out_sum[SIZE_ADC_DATA-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc         <= '0;
            pend        <= 1'b0;
            adc_data    <= '0;
            data_valid  <= 1'b0;
            pulse_start <= 1'b0;
        end else begin
            data_valid  <= sample_en;
            pulse_start <= sample_en & inject;
            if (sample_en) begin
                acc      <= acc_nxt;
                adc_data <= adc_nxt;
                pend     <= 1'b0;
            end else if (trig) begin
                pend <= 1'b1;
            end
        end
    end

    assign busy = (acc != '0) | pend;

endmodule
